// File: rtl/block_padder.sv
// Packs a byte-wide message stream MSB-first into block_size-bit blocks and
// appends ISO/IEC 7816-4 padding (0x80 then zeros) after the last message byte.
module block_padder #(
  parameter int block_size = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [block_size-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  localparam int N  = block_size / 8;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
  localparam logic [block_size-1:0] PAD_BLOCK = {8'h80, {(block_size - 8){1'b0}}};

  typedef enum logic {FILL, PAD} state_t;

  state_t                  state_reg, state_next;
  logic [block_size-1:0]   asm_reg, asm_next;
  logic [block_size-1:0]   data_reg, data_next;
  logic [CW-1:0]           cnt_reg, cnt_next;
  logic                    valid_reg, valid_next;
  logic                    last_reg, last_next;
  logic [block_size-1:0]   merged;
  logic [block_size-1:0]   padded;
  logic                    slot_free;
  logic                    byte_fire;

  // merged = assembly register with the incoming byte dropped into lane cnt;
  // padded additionally places 0x80 in lane cnt+1 (later lanes are already zero).
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    localparam int HI = block_size - 1 - 8 * gi;
    assign merged[HI -: 8] = (cnt_reg == CW'(gi)) ? s_axis_tdata : asm_reg[HI -: 8];
    if (gi == 0) begin : g_first
      assign padded[HI -: 8] = merged[HI -: 8];
    end else begin : g_rest
      assign padded[HI -: 8] = (cnt_reg == CW'(gi - 1)) ? 8'h80 : merged[HI -: 8];
    end
  end

  assign slot_free     = ~valid_reg | m_axis_tready;
  assign s_axis_tready = ~rst & (state_reg == FILL) & slot_free;
  assign byte_fire     = s_axis_tvalid & s_axis_tready;

  always_comb begin
    state_next = state_reg;
    asm_next   = asm_reg;
    cnt_next   = cnt_reg;
    data_next  = data_reg;
    last_next  = last_reg;
    valid_next = valid_reg & ~m_axis_tready;

    case (state_reg)
      FILL: begin
        if (byte_fire) begin
          if (cnt_reg == LAST_IDX) begin
            // Full block: if it also ends the message, padding spills into a new block.
            data_next  = merged;
            valid_next = 1'b1;
            last_next  = 1'b0;
            cnt_next   = '0;
            asm_next   = '0;
            if (s_axis_tlast) state_next = PAD;
          end else if (s_axis_tlast) begin
            data_next  = padded;
            valid_next = 1'b1;
            last_next  = 1'b1;
            cnt_next   = '0;
            asm_next   = '0;
          end else begin
            asm_next = merged;
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end
      PAD: begin
        if (slot_free) begin
          data_next  = PAD_BLOCK;
          valid_next = 1'b1;
          last_next  = 1'b1;
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= FILL;
      asm_reg   <= '0;
      cnt_reg   <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      asm_reg   <= asm_next;
      cnt_reg   <= cnt_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      last_reg  <= last_next;
    end
  end

  assign m_axis_tdata  = data_reg;
  assign m_axis_tvalid = valid_reg;
  assign m_axis_tlast  = last_reg;

endmodule

// File: tb/tb_block_padder.sv
// Self-checking bench for block_padder: directed framing cases, backpressure,
// reset handling and randomized messages against a message-level padding model.
module tb_block_padder;

  localparam int BS = 64;
  localparam int N  = BS / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic [BS-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tlast;

  int n_cmp = 0;
  int n_bad = 0;
  int stalls;

  logic [7:0]    msg_q[$];
  logic [BS-1:0] exp_d[$];
  bit            exp_l[$];
  logic [BS-1:0] got_d[$];
  bit            got_l[$];

  block_padder #(.block_size(BS)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast)
  );

  always #5 clk = ~clk;

  // Output handshakes seen at the negedge complete on the following posedge.
  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      got_d.push_back(m_tdata);
      got_l.push_back(m_tlast);
    end
  end

  // Queues the expected blocks for msg_q, then drives its bytes into the DUT.
  task automatic send_msg(input bit rnd, input bit with_last);
    logic [7:0]    pad_q[$];
    logic [BS-1:0] blk;
    int            nb;
    int            budget;
    bit            accepted;
    pad_q = msg_q;
    if (with_last) begin
      pad_q.push_back(8'h80);
      while (pad_q.size() % N != 0) pad_q.push_back(8'h00);
    end
    nb = pad_q.size() / N;
    for (int b = 0; b < nb; b++) begin
      blk = '0;
      for (int k = 0; k < N; k++) blk = {blk[BS-9:0], pad_q[b*N+k]};
      exp_d.push_back(blk);
      exp_l.push_back(with_last && (b == nb - 1));
    end
    stalls = 0;
    for (int i = 0; i < msg_q.size(); i++) begin
      if (rnd) begin
        while ($urandom_range(0, 3) == 0) begin
          s_tvalid = 1'b0;
          @(posedge clk); #1;
          m_tready = 1'($urandom_range(0, 1));
        end
      end
      s_tvalid = 1'b1;
      s_tdata  = msg_q[i];
      s_tlast  = with_last && (i == msg_q.size() - 1);
      budget   = 0;
      forever begin
        @(negedge clk);
        accepted = s_tready;
        @(posedge clk); #1;
        if (rnd) m_tready = 1'($urandom_range(0, 1));
        if (accepted) break;
        stalls++;
        budget++;
        if (budget > 200) begin
          n_cmp++; n_bad++;
          $display("FAIL send_timeout: byte %0d not accepted after %0d cycles, required acceptance", i, budget);
          break;
        end
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    m_tready = 1'b1;
    s_tvalid = 1'b0;
    for (int i = 0; i < 200 && got_d.size() < exp_d.size(); i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_tvalid = 1'b1; s_tdata = 8'h33; m_tready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid: got %b want 0", m_tvalid); end
    n_cmp++; if (m_tdata !== '0) begin n_bad++; $display("FAIL reset_tdata: got %h want 0", m_tdata); end
    n_cmp++; if (m_tlast !== 1'b0) begin n_bad++; $display("FAIL reset_tlast: got %b want 0", m_tlast); end
    n_cmp++; if (s_tready !== 1'b0) begin n_bad++; $display("FAIL reset_s_tready: got %b want 0", s_tready); end
    s_tvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (s_tready !== 1'b1) begin n_bad++; $display("FAIL post_reset_s_tready: got %b want 1", s_tready); end
    n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL post_reset_tvalid: got %b want 0", m_tvalid); end
    @(posedge clk); #1;
    $display("test_reset done");
  endtask

  task automatic test_directed();
    logic [7:0] base [4] = '{8'h01, 8'h11, 8'hA0, 8'h01};
    logic [7:0] step [4] = '{8'h01, 8'h11, 8'h01, 8'h01};
    int         len  [4] = '{8, 3, 8, 7};
    bit         lst  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] v;
    for (int c = 0; c < 4; c++) begin
      msg_q.delete();
      v = base[c];
      for (int k = 0; k < len[c]; k++) begin msg_q.push_back(v); v = v + step[c]; end
      m_tready = 1'b1;
      send_msg(1'b0, lst[c]);
      n_cmp++; if (stalls !== 0) begin n_bad++; $display("FAIL case%0d_stalls: got %0d want 0", c, stalls); end
      @(negedge clk);
      if (c == 0) begin
        n_cmp++; if (m_tvalid !== 1'b1 || m_tdata !== 64'h0102030405060708 || m_tlast !== 1'b0) begin
          n_bad++; $display("FAIL full_latency: got v=%b d=%h l=%b want v=1 d=0102030405060708 l=0", m_tvalid, m_tdata, m_tlast);
        end
      end
      if (c == 2) begin
        n_cmp++; if (s_tready !== 1'b0 || m_tdata !== 64'hA0A1A2A3A4A5A6A7 || m_tlast !== 1'b0) begin
          n_bad++; $display("FAIL exact_first: got rdy=%b d=%h l=%b want rdy=0 d=a0a1a2a3a4a5a6a7 l=0", s_tready, m_tdata, m_tlast);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (m_tvalid !== 1'b1 || m_tdata !== 64'h8000000000000000 || m_tlast !== 1'b1 || s_tready !== 1'b1) begin
          n_bad++; $display("FAIL exact_pad: got v=%b d=%h l=%b rdy=%b want v=1 d=8000000000000000 l=1 rdy=1", m_tvalid, m_tdata, m_tlast, s_tready);
        end
      end
      drain();
      n_cmp++; if (got_d.size() !== exp_d.size()) begin n_bad++; $display("FAIL case%0d_count: got %0d blocks want %0d", c, got_d.size(), exp_d.size()); end
      for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
        n_cmp++; if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
          n_bad++; $display("FAIL case%0d_block%0d: got %h/%b want %h/%b", c, i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
        end
      end
      $display("directed case %0d: %0d blocks", c, got_d.size());
      got_d.delete(); got_l.delete(); exp_d.delete(); exp_l.delete();
    end
  endtask

  task automatic test_backpressure();
    logic [BS-1:0] held;
    msg_q.delete();
    for (int k = 0; k < N; k++) msg_q.push_back(8'hC0 + 8'(k));
    m_tready = 1'b0;
    send_msg(1'b0, 1'b0);
    s_tvalid = 1'b1; s_tdata = 8'hEE; s_tlast = 1'b0;
    held = 64'hC0C1C2C3C4C5C6C7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (m_tvalid !== 1'b1 || m_tdata !== held || m_tlast !== 1'b0 || s_tready !== 1'b0) begin
        n_bad++; $display("FAIL bp_hold%0d: got v=%b d=%h l=%b rdy=%b want v=1 d=%h l=0 rdy=0", i, m_tvalid, m_tdata, m_tlast, s_tready, held);
      end
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    @(negedge clk);
    n_cmp++; if (s_tready !== 1'b1) begin n_bad++; $display("FAIL bp_release_rdy: got %b want 1", s_tready); end
    drain();
    n_cmp++; if (got_d.size() !== exp_d.size()) begin n_bad++; $display("FAIL bp_count: got %0d blocks want %0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      n_cmp++; if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        n_bad++; $display("FAIL bp_block%0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
    $display("backpressure: %0d blocks", got_d.size());
    got_d.delete(); got_l.delete(); exp_d.delete(); exp_l.delete();
  endtask

  task automatic test_reset_mid();
    msg_q.delete();
    repeat (4) msg_q.push_back(8'hFF);
    m_tready = 1'b1;
    send_msg(1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (m_tvalid !== 1'b0 || m_tdata !== '0 || m_tlast !== 1'b0 || s_tready !== 1'b0) begin
      n_bad++; $display("FAIL midreset_outputs: got v=%b d=%h l=%b rdy=%b want all 0", m_tvalid, m_tdata, m_tlast, s_tready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    msg_q.delete();
    msg_q.push_back(8'h5A);
    send_msg(1'b0, 1'b1);
    drain();
    n_cmp++; if (got_d.size() !== 1) begin n_bad++; $display("FAIL midreset_count: got %0d blocks want 1", got_d.size()); end
    if (got_d.size() > 0) begin
      n_cmp++; if (got_d[0] !== 64'h5A80000000000000 || got_l[0] !== 1'b1) begin
        n_bad++; $display("FAIL midreset_block: got %h/%b want 5a80000000000000/1", got_d[0], got_l[0]);
      end
    end
    $display("reset mid-message: %0d blocks", got_d.size());
    got_d.delete(); got_l.delete(); exp_d.delete(); exp_l.delete();
  endtask

  task automatic test_random();
    int nmsg;
    for (int m = 0; m < 40; m++) begin
      msg_q.delete();
      nmsg = $urandom_range(1, 20);
      for (int k = 0; k < nmsg; k++) msg_q.push_back(8'($urandom));
      send_msg(1'b1, 1'b1);
      $display("random msg %0d: %0d bytes, %0d stalls", m, nmsg, stalls);
    end
    drain();
    n_cmp++; if (got_d.size() !== exp_d.size()) begin n_bad++; $display("FAIL rand_count: got %0d blocks want %0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      n_cmp++; if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        n_bad++; $display("FAIL rand_block%0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
    got_d.delete(); got_l.delete(); exp_d.delete(); exp_l.delete();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/block_padder.md
Name: block_padder

Overview:
- Upstream framing stage for the MacGuffin cipher core.
- Accepts a byte-wide AXI4-Stream message and packs bytes MSB-first into block_size-bit blocks.
- Applies ISO/IEC 7816-4 padding: one 0x80 byte after the last message byte, then zero bytes to the end of the block.
- Output is a block-wide AXI4-Stream that connects directly to the cipher's s_axis port. m_axis_tlast marks the final block of each message.

Parameters:
- block_size, 64, output block width in bits; must be a multiple of 8 and at least 16.
- N (localparam), block_size/8, bytes per block.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- s_axis_tdata  in  8  message byte
- s_axis_tvalid  in  1  byte valid
- s_axis_tready  out  1  byte accepted when high with tvalid
- s_axis_tlast  in  1  byte is the last of the message
- m_axis_tdata  out  block_size  packed/padded block
- m_axis_tvalid  out  1  block valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  block is the last of the message

Behaviour:
- Clock and reset: single clock clk. Reset rst is asynchronous, active-high.
- Reset values:
  - m_axis_tdata = 0, m_axis_tvalid = 0, m_axis_tlast = 0.
  - Assembly register = 0, byte counter cnt = 0, state = FILL.
  - s_axis_tready = 0 while rst is high.
- State machine has two states: FILL (collecting bytes) and PAD (extra padding block pending).
- Output slot is free when m_axis_tvalid = 0 or m_axis_tready = 1.
- s_axis_tready = (state == FILL) and the output slot is free. Combinational, no dependence on s_axis_tvalid.
- Byte placement: byte index i (0-based within a block) lands in bits [block_size-1-8i : block_size-8-8i]. The first byte goes in the MSBs.
- On an accepted byte with tlast = 0:
  - cnt < N-1: write the byte at position cnt, then cnt++.
  - cnt = N-1: load the output register with the full block, m_axis_tlast = 0, cnt = 0, clear the assembly register.
- On an accepted byte with tlast = 1:
  - cnt < N-1: the output block is the collected bytes, then this byte, then 0x80 at position cnt+1, then zeros. m_axis_tlast = 1, cnt = 0, clear the assembly register.
  - cnt = N-1: the output block is the full block with m_axis_tlast = 0. Move to PAD.
- In PAD, when the output slot is free:
  - Load 0x80 followed by zeros (0x80 << (block_size-8)), with m_axis_tlast = 1.
  - Return to FILL. No input bytes are accepted while in PAD.
- Output register:
  - A loaded block appears on m_axis_* the cycle after the completing byte handshake (latency 1).
  - When m_axis_tready = 1 and no new block is loaded that cycle, m_axis_tvalid drops to 0.
  - Held valid data is stable (tdata, tlast unchanged) until accepted.
- Throughput: 1 byte/cycle sustained with m_axis_tready = 1. Emission and reload in the same cycle are allowed; the output register updates directly.
- An empty message is impossible: tlast always accompanies a data byte.
- Consecutive messages need no idle gap. The first byte of the next message can be accepted the cycle after tlast (FILL state).
- Reset mid-operation: all state is cleared immediately. A partially collected block is discarded, and a pending PAD block or pending output is dropped.

Test Plan:
- Full block: bytes 0x01..0x08, tlast = 0, m_axis_tready = 1 -> one block 0x0102030405060708 with m_axis_tlast = 0, valid the cycle after the 8th byte. s_axis_tready stays 1 throughout.
- Short message: bytes 0x11, 0x22, 0x33 with tlast on 0x33 -> block 0x1122338000000000 with m_axis_tlast = 1.
- Exact multiple: bytes 0xA0..0xA7 with tlast on 0xA7 -> block 0xA0A1A2A3A4A5A6A7 (tlast 0), then block 0x8000000000000000 (tlast 1). s_axis_tready = 0 for the PAD cycle.
- Seven-byte message: 0x01..0x07 with tlast on the 7th -> 0x0102030405060780 with tlast = 1, no extra block.
- Backpressure: complete a block while m_axis_tready = 0 for 5 cycles -> m_axis_tvalid = 1 with tdata and tlast stable, s_axis_tready = 0. On tready the block is accepted and s_axis_tready returns to 1 in the same cycle.
- Reset mid-message:
  - Send 4 bytes 0xFF, pulse rst, then send 0x5A with tlast.
  - Required output: single block 0x5A80000000000000 with tlast = 1.
  - All outputs read 0 during reset.
